uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer, 434 at defaults), HALF = DIV/2.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_io  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 data_out  output  8  last received byte; stable while valid=1.
REQ-007 valid  output  1  received byte available; held until acknowledged.
REQ-008 ack  input  1  consumer accepts data_out; meaningful only when valid=1.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit (or a bad parity bit when REQ-030 is active).
REQ-010 overrun  output  1  sticky; a completed byte was discarded because valid was still 1.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 rx_io shall pass through a 2-FF synchronizer (both stages reset to 1) before any use; the second stage is rx_s.
REQ-013 FSM states shall be IDLE, START, DATA, PARITY (compiled only under REQ-030), STOP and WAIT_HIGH.
REQ-014 IDLE -> START when rx_s=0; the baud counter loads HALF-1.
REQ-015 START: when the counter reaches 0, rx_s=0 -> DATA with counter DIV-1 and bit index 0; rx_s=1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: at each counter expiry, sample rx_s into shift bit [index] (LSB first) and reload DIV-1; after index 7 -> STOP (or PARITY under REQ-030).
REQ-017 STOP: at counter expiry with rx_s=1 (good frame) -> IDLE and deliver the byte per REQ-019..REQ-021.
REQ-018 STOP: at counter expiry with rx_s=0 -> WAIT_HIGH; frame_err pulses for one cycle; the byte is not delivered; WAIT_HIGH -> IDLE on the first cycle with rx_s=1 (break-safe).
REQ-019 Delivery with valid=0: data_out <= byte and valid <= 1 in the cycle after the stop-bit sample.
REQ-020 Delivery with valid=1 and ack=0: the byte is discarded, data_out is unchanged, and overrun <= 1.
REQ-021 Delivery and ack in the same cycle: the new byte is loaded, valid stays 1, and overrun is not set.
REQ-022 ack with valid=1 and no delivery: valid <= 0 and overrun <= 0 in the next cycle; ack with valid=0 shall be ignored.
REQ-023 Latency from the falling edge of the rx_io start bit to valid shall be 2 (synchronizer) + HALF + 9*DIV + 1 cycles, with ±1 cycle for edge phase.
REQ-024 The baud counter shall be ceil(log2(DIV)) bits wide; the counter and bit index shall never wrap mid-frame.
REQ-025 rx_io activity in WAIT_HIGH or during a frame shall not restart the frame; only IDLE detects a start bit.

Reset
REQ-026 Asserting rst at any time, including mid-frame, shall force: state IDLE, synchronizer stages 1, data_out 8'h00, valid 0, frame_err 0, overrun 0, busy 0, counter and index 0.
REQ-027 After rst deasserts, a frame already in progress on the line shall not be decoded until the line returns to idle and a new falling edge occurs (REQ-014 requires rx_s=0 seen from IDLE; the 1-reset synchronizer guarantees an edge).

Configuration
REQ-028 Macro UART_RX_PARITY_EN selects even-parity framing (8E1).
REQ-029 Without UART_RX_PARITY_EN: no PARITY state; frame = start + 8 data + stop; REQ-023 latency applies.
REQ-030 With UART_RX_PARITY_EN: DATA -> PARITY; one sample after DIV; parity error when XOR(byte, parity bit) = 1; -> STOP regardless; a parity error shall pulse frame_err at the stop sample and suppress delivery; latency is REQ-023 plus DIV.

Verification
REQ-031 Defaults, send 8'hA5 8N1 at 115200 -> valid=1, data_out=8'hA5, frame_err=0, overrun=0; ack -> valid=0 next cycle.
REQ-032 Low pulse of 100 cycles (< HALF=217) on an idle line -> returns to IDLE, valid remains 0, no frame_err.
REQ-033 Send 8'h3C with stop bit forced 0, line held low 2000 cycles then high -> frame_err one pulse, valid=0, busy stays 1 until the line goes high.
REQ-034 Send 8'h11 then 8'h22 without ack -> data_out=8'h11, overrun=1; ack -> valid=0, overrun=0.
REQ-035 Assert rst at mid-bit 4 of 8'hFF, release, send 8'h5A -> only 8'h5A delivered, all outputs at reset values during rst.
REQ-036 UART_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> delivered; same byte with parity bit 0 -> frame_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a single-entry holding register and valid/ack handshake.
//
// Parameters:
//   CLK_FREQ   input clock frequency in Hz
//   BAUD_RATE  line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE, HALF = DIV/2
//
// Ports:
//   clk        clock, all logic on its rising edge
//   rst        asynchronous active-high reset
//   rx_io      asynchronous serial line, idle high, LSB first
//   data_out   last received byte, stable while valid is high
//   valid      byte available, held until ack
//   ack        consumer accepts data_out (ignored while valid is low)
//   frame_err  one-cycle pulse on a bad stop bit (or bad parity)
//   overrun    sticky, a completed byte was dropped because valid was still high
//   busy       high whenever the receiver is not idle
//
// Optional feature: define UART_RX_PARITY_EN for even-parity framing (8E1).
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_io,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LoadFull = CW'(DIV - 1);
  localparam logic [CW-1:0] LoadHalf = CW'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  logic          sync1_q, rx_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          deliver;
  logic          expired;
  logic          par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  assign expired   = (cnt_q == '0);
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

  // Stages reset to 1 so a line held low across reset never looks like a fresh start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_io;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = LoadHalf;
        end
      end
      StStart: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s) begin
          state_d = StData;
          cnt_d   = LoadFull;
          idx_d   = '0;
        end else begin
          // Start bit vanished by mid-bit: treat as a glitch.
          state_d = StIdle;
        end
      end
      StData: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = LoadFull;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          par_err_d = (^shift_q) ^ rx_s;
          cnt_d     = LoadFull;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s) begin
          // Bad stop bit: wait out a possible break before hunting for a new start.
          ferr_d  = 1'b1;
          state_d = StWaitHigh;
        end else if (par_bad) begin
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          deliver = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Holding register handshake; an ack in the delivery cycle frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at default parameters.
// Bytes expected to be delivered are queued when their frame is driven and
// compared against data_out when valid is observed.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 2 + HALF + 10 * DIV + 1;
`else
  localparam int EXP_LAT = 2 + HALF + 9 * DIV + 1;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx_io = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_io    (rx_io),
    .data_out (data_out),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int dlv_cnt  = 0;
  int rise_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] sb[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Count frame_err high cycles and valid rising edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (valid === 1'b1 && valid_prev !== 1'b1) begin
      dlv_cnt  <= dlv_cnt + 1;
      rise_cyc <= cyc;
    end
    valid_prev <= valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_io = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_io = b[i];
      tick(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rx_io = (^b) ^ par_flip;
    tick(DIV);
`endif
    rx_io = stop_bit;
    tick(DIV);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 2 * DIV) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed 0x%0h expected <scoreboard empty>", tag, data_out);
    end else begin
      e = sb.pop_front();
      check(tag, {24'd0, data_out}, {24'd0, e});
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    int c0;
    int fe0;
    int d0;

    // Reset state
    tick(3);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Good frame 0xA5 plus latency
    fe0 = fe_cnt;
    c0  = cyc;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid");
    pop_check("a5_data");
    check("a5_ferr", fe_cnt, fe0);
    check("a5_ovr", {31'd0, overrun}, 32'd0);
    check("a5_lat_ok", {31'd0, ((rise_cyc - c0) >= EXP_LAT - 1) && ((rise_cyc - c0) <= EXP_LAT + 1)},
          32'd1);
    do_ack();
    check("a5_ack_valid", {31'd0, valid}, 32'd0);
    tick(10);

    // Short low glitch rejected
    fe0   = fe_cnt;
    rx_io = 1'b0;
    tick(50);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    tick(50);
    rx_io = 1'b1;
    tick(300);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, valid}, 32'd0);
    check("glitch_ferr", fe_cnt, fe0);

    // Bad stop bit followed by a long break
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    tick(2000);
    check("brk_busy_hi", {31'd0, busy}, 32'd1);
    check("brk_ferr_pulse", fe_cnt, fe0 + 1);
    check("brk_valid", {31'd0, valid}, 32'd0);
    rx_io = 1'b1;
    tick(4);
    check("brk_busy_lo", {31'd0, busy}, 32'd0);
    tick(20);

    // Overrun: second byte dropped while the first is unacknowledged
    d0 = dlv_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    pop_check("ovr_data");
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_one_rise", dlv_cnt, d0 + 1);
    do_ack();
    check("ovr_ack_valid", {31'd0, valid}, 32'd0);
    check("ovr_ack_flag", {31'd0, overrun}, 32'd0);
    tick(10);

    // Reset mid-bit 4 of 0xFF, then a clean 0x5A
    rx_io = 1'b0;
    tick(DIV);
    rx_io = 1'b1;
    tick(4 * DIV + HALF);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(3);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    check("mrst_data", {24'd0, data_out}, 32'h00);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    check("mrst_ovr", {31'd0, overrun}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5 * DIV);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    fe0 = fe_cnt;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_valid("5a_valid");
    pop_check("5a_data");
    check("5a_ferr", fe_cnt, fe0);
    do_ack();
    tick(10);

`ifdef UART_RX_PARITY_EN
    // Even parity: good then bad parity bit on 0x07
    fe0      = fe_cnt;
    par_flip = 1'b0;
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    wait_valid("par_good_valid");
    pop_check("par_good_data");
    do_ack();
    tick(10);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(5);
    check("par_bad_ferr", fe_cnt, fe0 + 1);
    check("par_bad_valid", {31'd0, valid}, 32'd0);
    par_flip = 1'b0;
    tick(10);
    check("total_rises", dlv_cnt, 4);
`else
    check("total_rises", dlv_cnt, 3);
`endif
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
